// File: rtl/fp32_add_arb_if.sv
// Requester, shared-adder and response signals of the fp32 adder arbiter.
// slave is the arbiter's view; master is the environment (requesters + adder).
interface fp32_add_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic                add_valid_in;
  logic [31:0]         add_a;
  logic [31:0]         add_b;
  logic                add_valid_out;
  logic [31:0]         add_y;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_y;
  logic                drain_req;
  logic                drain_done;
  logic                err_orphan;

  modport slave (
    input  req_valid, req_a, req_b, add_valid_out, add_y, drain_req,
    output req_ready, add_valid_in, add_a, add_b, rsp_valid, rsp_y,
           drain_done, err_orphan
  );

  modport master (
    output req_valid, req_a, req_b, add_valid_out, add_y, drain_req,
    input  req_ready, add_valid_in, add_a, add_b, rsp_valid, rsp_y,
           drain_done, err_orphan
  );
endinterface

// File: rtl/fp32_add_arb.sv
// Shares one fixed-latency fp32 adder among N_REQ requesters with tag routing and drain control.
// Define FP32_ADD_ARB_FIXED_PRIO_EN for fixed-priority arbitration (default: round-robin).
module fp32_add_arb #(
  parameter int N_REQ     = 4,
  parameter int ADD_LAT   = 3,
  parameter int MAX_OUTST = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fp32_add_arb_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;
  state_t state, state_nxt;

  logic [2:0]       outst     [N_REQ];
  logic [2:0]       outst_eff [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic             gnt_any, lo_any, idle, hit;
  logic [IW-1:0]    gnt_idx, lo_idx;
  logic [31:0]      sel_a, sel_b;
  logic [ADD_LAT:0] tag_v;
  logic [IW-1:0]    tag_id [ADD_LAT+1];

  always_comb begin
    idle = ~|tag_v;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // a response retiring this cycle frees its slot for a same-cycle grant
      outst_eff[i] = outst[i] - 3'(bus.rsp_valid[i]);
      elig[i]      = bus.req_valid[i] && (outst_eff[i] < 3'(MAX_OUTST)) && (state == RUN);
      if (outst_eff[i] != '0) idle = 1'b0;
    end
  end

  always_comb begin
    lo_any = 1'b0;
    lo_idx = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (elig[i-1]) begin
        lo_any = 1'b1;
        lo_idx = IW'(i - 1);
      end
    end
  end

`ifdef FP32_ADD_ARB_FIXED_PRIO_EN
  assign gnt_any = lo_any;
  assign gnt_idx = lo_idx;
`else
  logic [IW-1:0] ptr;
  logic          hi_any;
  logic [IW-1:0] hi_idx;

  // first eligible at or above the pointer, else wrap to the lowest eligible
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (elig[i-1] && (IW'(i - 1) >= ptr)) begin
        hi_any = 1'b1;
        hi_idx = IW'(i - 1);
      end
    end
    gnt_any = lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (gnt_any) ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  assign gnt           = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  assign bus.req_ready = gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  assign hit = bus.add_valid_out && tag_v[ADD_LAT];

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.drain_req) state_nxt = DRAIN;
      DRAIN:   if (idle) state_nxt = DRAINED;
               else if (!bus.drain_req) state_nxt = RUN;
      DRAINED: if (!bus.drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign bus.drain_done = (state == DRAINED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.add_valid_in <= 1'b0;
      bus.add_a        <= '0;
      bus.add_b        <= '0;
      bus.rsp_valid    <= '0;
      bus.rsp_y        <= '0;
      bus.err_orphan   <= 1'b0;
      tag_v            <= '0;
      for (int unsigned k = 0; k <= ADD_LAT; k++) tag_id[k] <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) outst[i] <= '0;
    end else begin
      bus.add_valid_in <= gnt_any;
      if (gnt_any) begin
        bus.add_a <= sel_a;
        bus.add_b <= sel_b;
      end
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_idx;
      for (int unsigned k = 1; k <= ADD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      bus.rsp_valid <= hit ? (N_REQ'(1) << tag_id[ADD_LAT]) : '0;
      if (hit) bus.rsp_y <= bus.add_y;
      if (bus.add_valid_out && !tag_v[ADD_LAT]) bus.err_orphan <= 1'b1;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        case ({gnt[i], bus.rsp_valid[i]})
          2'b10:   outst[i] <= outst[i] + 3'd1;
          2'b01:   outst[i] <= outst[i] - 3'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fp32_add_arb.sv
// Scoreboard bench for fp32_add_arb with a behavioural fixed-latency fp32 adder attached.
// Expectations are pushed at issue time; a negedge monitor pops them on every rsp_valid.
module tb_fp32_add_arb;
  localparam int N_REQ     = 4;
  localparam int ADD_LAT   = 3;
  localparam int MAX_OUTST = 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic force_vo = 1'b0;
  int   n_cmp    = 0;
  int   n_err    = 0;

  fp32_add_arb_if #(.N_REQ(N_REQ)) bus ();

  fp32_add_arb #(.N_REQ(N_REQ), .ADD_LAT(ADD_LAT), .MAX_OUTST(MAX_OUTST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] f2d(logic [31:0] f);
    if (f[30:23] == 8'd0) return '0;
    return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(logic [63:0] d);
    logic [10:0] e;
    e = d[62:52];
    if (e == 11'd0) return '0;
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    real r;
    r = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
    return d2f($realtobits(r));
  endfunction

  // attached adder: not reset by rst_n, so in-flight results survive an arbiter reset
  logic [ADD_LAT-1:0] av = '0;
  logic [31:0]        ay [ADD_LAT];
  always @(posedge clk) begin
    av    <= {av[ADD_LAT-2:0], bus.add_valid_in};
    ay[0] <= fadd(bus.add_a, bus.add_b);
    for (int k = 1; k < ADD_LAT; k++) ay[k] <= ay[k-1];
  end
  assign bus.add_valid_out = av[ADD_LAT-1] | force_vo;
  assign bus.add_y         = ay[ADD_LAT-1];

  typedef struct packed {
    logic [3:0]  oh;
    logic [31:0] y;
  } exp_t;
  exp_t        sbq [$];
  logic [31:0] exp_y [N_REQ];

  logic [3:0] p_rr  [8]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0] p_fix [6]  = '{4'h2, 4'h2, 4'h8, 4'h8, 4'h0, 4'h2};
  logic [3:0] p_lim [10] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
  logic       p_dd  [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic [31:0] y);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    exp_y[i] = y;
  endtask

  task automatic expect_cycle(string nm, logic [3:0] rdy);
    @(negedge clk);
    check(nm, 32'(bus.req_ready), 32'(rdy));
    for (int i = 0; i < N_REQ; i++)
      if (rdy[i]) sbq.push_back('{oh: rdy, y: exp_y[i]});
    step();
  endtask

  task automatic wait_empty(string nm);
    for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
    check(nm, 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b rsp_y=%h, required no response (t=%0t)",
                 bus.rsp_valid, bus.rsp_y, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_valid", 32'(bus.rsp_valid), 32'(e.oh));
        check("rsp_y", bus.rsp_y, e.y);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.drain_req = 1'b0;
    #2;
    check("rst_add_valid_in", 32'(bus.add_valid_in), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_add_a", bus.add_a, 32'd0);
    check("rst_rsp_y", bus.rsp_y, 32'd0);
    check("rst_err_orphan", 32'(bus.err_orphan), 32'd0);
    check("rst_drain_done", 32'(bus.drain_done), 32'd0);
    step();

    // single request from requester 2: 1.0 + 2.0
    set_op(2, 32'h3F800000, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0100;
    expect_cycle("t1_ready", 4'b0100);
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_add_valid_in", 32'(bus.add_valid_in), 32'd1);
    check("t1_add_a", bus.add_a, 32'h3F800000);
    check("t1_add_b", bus.add_b, 32'h40000000);
    lat = 1;
    while (bus.rsp_valid == '0 && lat < 10) begin
      step();
      @(negedge clk);
      lat++;
    end
    check("t1_latency", lat, 5);
    step();
    @(negedge clk);
    check("t1_add_valid_idle", 32'(bus.add_valid_in), 32'd0);
    check("t1_add_a_hold", bus.add_a, 32'h3F800000);
    wait_empty("t1_sb_empty");
    do_reset();

    set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_op(1, 32'h3FC00000, 32'h3F000000, 32'h40000000);
    set_op(2, 32'h40000000, 32'h40000000, 32'h40800000);
    set_op(3, 32'h3F000000, 32'h3F000000, 32'h3F800000);
`ifdef FP32_ADD_ARB_FIXED_PRIO_EN
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) expect_cycle("fix_ready", p_fix[k]);
`else
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) expect_cycle("rr_ready", p_rr[k]);
`endif
    bus.req_valid = '0;
    wait_empty("t2_sb_empty");
    do_reset();

    // requester 0 alone against the outstanding limit: 4.0 + 4.0
    set_op(0, 32'h40800000, 32'h40800000, 32'h41000000);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) expect_cycle("lim_ready", p_lim[k]);
    bus.req_valid = '0;
    wait_empty("t3_sb_empty");
    do_reset();

    // drain with three operations in flight
    set_op(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_op(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    set_op(2, 32'h40000000, 32'h3F800000, 32'h40400000);
    bus.req_valid = 4'b0111;
    expect_cycle("dr_ready0", 4'b0001);
    expect_cycle("dr_ready1", 4'b0010);
    bus.drain_req = 1'b1;
    expect_cycle("dr_ready2", 4'b0100);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("dr_no_grant", 32'(bus.req_ready), 32'd0);
      check("dr_done", 32'(bus.drain_done), 32'(p_dd[k]));
      step();
    end
    bus.drain_req = 1'b0;
    @(negedge clk);
    check("dr_still_done", 32'(bus.drain_done), 32'd1);
    check("dr_no_grant_yet", 32'(bus.req_ready), 32'd0);
    step();
    @(negedge clk);
    check("dr_done_cleared", 32'(bus.drain_done), 32'd0);
    step();
    bus.req_valid = '0;
    wait_empty("t4_sb_empty");
    do_reset();

    // forced orphan result
    force_vo = 1'b1;
    step();
    force_vo = 1'b0;
    @(negedge clk);
    check("orph_set", 32'(bus.err_orphan), 32'd1);
    check("orph_no_rsp", 32'(bus.rsp_valid), 32'd0);
    repeat (4) step();
    @(negedge clk);
    check("orph_sticky", 32'(bus.err_orphan), 32'd1);
    step();
    rst_n = 1'b0;
    #2;
    check("orph_cleared", 32'(bus.err_orphan), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // reset with a result in flight: the late result must be flagged
    set_op(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    step();
    rst_n = 1'b0;
    #2;
    check("mid_rst_add_valid", 32'(bus.add_valid_in), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_orph_pre", 32'(bus.err_orphan), 32'd0);
    step();
    @(negedge clk);
    check("mid_rst_orph", 32'(bus.err_orphan), 32'd1);
    check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    check("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
